// File: rtl/dmem_arbiter_pkg.sv
// Shared dmem definitions: data width, depth, address width and arbiter state encodings.
// No logic; imported by the arbiter and its statistics counters.
package dmem_arbiter_pkg;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 256;
  localparam int DMEM_AW  = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;
endpackage

// File: rtl/dmem_arb_stats.sv
// Per-master access/wait counter pair; counters wrap and clear on rst_i.
// One-cycle update latency, never stalls the arbiter.
module dmem_arb_stats #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             gnt_i,
  output logic [CNT_W-1:0] acc_o,
  output logic [CNT_W-1:0] wait_o
);
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] wait_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      wait_q <= '0;
    end else begin
      if (gnt_i)          acc_q  <= acc_q + CNT_W'(1);
      if (req_i && !gnt_i) wait_q <= wait_q + CNT_W'(1);
    end
  end

  assign acc_o  = acc_q;
  assign wait_o = wait_q;
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-master arbiter for single-port dmem with burst lock; stats under DMEM_ARB_STATS_EN.
// One idle arbitration cycle from IDLE, handover without bubble; a master holds req until it sees gnt.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 8
`ifdef DMEM_ARB_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_req,
  input  logic               m0_we,
  input  logic               m0_lock,
  input  logic [DMEM_AW-1:0] m0_a,
  input  logic [DATA_W-1:0]  m0_wd,
  output logic               m0_gnt,
  output logic [DATA_W-1:0]  m0_rd,
  input  logic               m1_req,
  input  logic               m1_we,
  input  logic               m1_lock,
  input  logic [DMEM_AW-1:0] m1_a,
  input  logic [DATA_W-1:0]  m1_wd,
  output logic               m1_gnt,
  output logic [DATA_W-1:0]  m1_rd,
  output logic [DMEM_AW-1:0] mem_a,
  output logic [DATA_W-1:0]  mem_wd,
  output logic               mem_we,
  input  logic [DATA_W-1:0]  mem_rd
`ifdef DMEM_ARB_STATS_EN
  , output logic [CNT_W-1:0] stat0_acc
  , output logic [CNT_W-1:0] stat0_wait
  , output logic [CNT_W-1:0] stat1_acc
  , output logic [CNT_W-1:0] stat1_wait
`endif
);
  localparam logic [8:0] BURST_LIM = 9'(MAX_BURST);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] burst_q, burst_d;

  logic       own_id, own_req, oth_req, own_lock, burst_end;
  arb_state_e oth_state;

  assign m0_gnt = (state_q == ARB_OWN0) && m0_req;
  assign m1_gnt = (state_q == ARB_OWN1) && m1_req;
  assign m0_rd  = mem_rd;
  assign m1_rd  = mem_rd;

  always_comb begin
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 1'b0;
    if (state_q == ARB_OWN0) begin
      mem_a  = m0_a;
      mem_wd = m0_wd;
      mem_we = m0_gnt && m0_we;
    end else if (state_q == ARB_OWN1) begin
      mem_a  = m1_a;
      mem_wd = m1_wd;
      mem_we = m1_gnt && m1_we;
    end
  end

  // Owner-relative view so OWN0/OWN1 share one transition rule.
  always_comb begin
    own_id    = (state_q == ARB_OWN1);
    own_req   = own_id ? m1_req  : m0_req;
    oth_req   = own_id ? m0_req  : m1_req;
    own_lock  = own_id ? m1_lock : m0_lock;
    oth_state = own_id ? ARB_OWN0 : ARB_OWN1;
    burst_end = ({1'b0, burst_q} + 9'd1) >= BURST_LIM;

    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0_req && m1_req) state_d = last_q ? ARB_OWN0 : ARB_OWN1;
        else if (m0_req)      state_d = ARB_OWN0;
        else if (m1_req)      state_d = ARB_OWN1;
      end
      ARB_OWN0, ARB_OWN1: begin
        if (!own_req) begin
          burst_d = '0;
          state_d = oth_req ? oth_state : ARB_IDLE;
        end else begin
          last_d = own_id;
          if (oth_req && (!own_lock || burst_end)) begin
            state_d = oth_state;
            burst_d = '0;
          end else if (burst_q < BURST_MAX) begin
            burst_d = burst_q + 8'd1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats #(.CNT_W(CNT_W)) u_stats0 (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (m0_req),
    .gnt_i (m0_gnt),
    .acc_o (stat0_acc),
    .wait_o(stat0_wait)
  );
  dmem_arb_stats #(.CNT_W(CNT_W)) u_stats1 (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (m1_req),
    .gnt_i (m1_gnt),
    .acc_o (stat1_acc),
    .wait_o(stat1_wait)
  );
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench: dmem_arbiter plus a behavioural dmem (word i preloaded with 32'h080d0001 + i).
// Directed master drivers feed a grant-order / read-data scoreboard checked by a negedge monitor.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [31:0] wd;
    logic        lock;
    logic [31:0] exp;
    int          dly;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req  [2];
  logic        we   [2];
  logic        lock [2];
  logic [15:0] addr [2];
  logic [31:0] wd   [2];
  logic        m0_gnt, m1_gnt, mem_we;
  logic [31:0] m0_rd, m1_rd, mem_wd, mem_rd;
  logic [15:0] mem_a;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat0_acc, stat0_wait, stat1_acc, stat1_wait;
`endif

  logic [31:0] mem [0:DEPTH-1];

  op_t         opq   [2][$];
  logic [31:0] expq  [2][$];
  int          ord_q [$];
  bit          busy     [2] = '{0, 0};
  bit          gnt_seen [2] = '{0, 0};
  bit          drop     [2] = '{0, 0};
  int          dly_cnt  [2] = '{0, 0};
  int          gnt_cyc  [2] = '{0, 0};
  int          n_gnt    [2] = '{0, 0};
  int          cyc = 0;
  int          we_cycles = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rd = mem[mem_a[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:0]] <= mem_wd;

  dmem_arbiter #(.MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_lock(lock[0]), .m0_a(addr[0]), .m0_wd(wd[0]),
    .m0_gnt(m0_gnt), .m0_rd(m0_rd),
    .m1_req(req[1]), .m1_we(we[1]), .m1_lock(lock[1]), .m1_a(addr[1]), .m1_wd(wd[1]),
    .m1_gnt(m1_gnt), .m1_rd(m1_rd),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
`ifdef DMEM_ARB_STATS_EN
    , .stat0_acc(stat0_acc), .stat0_wait(stat0_wait)
    , .stat1_acc(stat1_acc), .stat1_wait(stat1_wait)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_op(input int n, input logic w, input logic [15:0] a, input logic [31:0] d,
                         input logic lk, input logic [31:0] e, input int dl);
    op_t o;
    o.we = w; o.a = a; o.wd = d; o.lock = lk; o.exp = e; o.dly = dl;
    opq[n].push_back(o);
  endtask

  task automatic wait_done(input string nm);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); #1;
      if (opq[0].size() == 0 && opq[1].size() == 0 && !busy[0] && !busy[1] &&
          ord_q.size() == 0 && expq[0].size() == 0 && expq[1].size() == 0) ok = 1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: timeout, got %0d pending grants expected 0", nm, ord_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Master drivers: present one op at a time, hold it until its grant has been seen.
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (drop[n]) begin
          busy[n] = 0; gnt_seen[n] = 0; req[n] = 1'b0; drop[n] = 0; dly_cnt[n] = 0;
        end
        if (busy[n] && gnt_seen[n]) begin
          busy[n] = 0; gnt_seen[n] = 0; req[n] = 1'b0;
        end
        if (!busy[n] && opq[n].size() > 0) begin
          if (dly_cnt[n] < opq[n][0].dly) dly_cnt[n]++;
          else begin
            op_t o;
            o = opq[n].pop_front();
            dly_cnt[n] = 0;
            req[n] = 1'b1; we[n] = o.we; lock[n] = o.lock; addr[n] = o.a; wd[n] = o.wd;
            busy[n] = 1;
            if (!o.we) expq[n].push_back(o.exp);
          end
        end
      end
    end
  end

  // Monitor: compares every grant against the expected order and read data.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) chk("rst_no_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
      if (mem_we) we_cycles++;
      if (m0_gnt || m1_gnt) chk("single_gnt", {31'd0, m0_gnt & m1_gnt}, 32'd0);
      for (int n = 0; n < 2; n++) begin
        logic g;
        logic [31:0] rd;
        g  = (n == 0) ? m0_gnt : m1_gnt;
        rd = (n == 0) ? m0_rd : m1_rd;
        if (g) begin
          gnt_seen[n] = 1; gnt_cyc[n] = cyc; n_gnt[n]++;
          if (ord_q.size() > 0) chk("gnt_order", 32'(n), 32'(ord_q.pop_front()));
          if (!we[n]) begin
            if (expq[n].size() > 0) chk($sformatf("m%0d_rd", n), rd, expq[n].pop_front());
            else begin
              total++; bad++;
              $display("FAIL m%0d_rd: unexpected read grant, got %h expected none", n, rd);
            end
          end
        end
      end
    end
  end

  initial begin
    int rel, start, base;
    bit hit;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h080d0001 + i;
    for (int n = 0; n < 2; n++) begin
      req[n] = 1'b0; we[n] = 1'b0; lock[n] = 1'b0; addr[n] = '0; wd[n] = '0;
    end

    // 1: request during reset, granted one cycle after release
    push_op(0, 1'b0, 16'h0000, 32'h0, 1'b0, 32'h080d0001, 0);
    ord_q.push_back(0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_a", {16'd0, mem_a}, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_m0_req_held", {31'd0, req[0]}, 32'd1);
    rst = 1'b0;
    rel = cyc;
    wait_done("t1");
    chk("t1_latency", 32'(gnt_cyc[0] - rel), 32'd1);

    // 2: both masters, no lock: strict alternation without bubble
    do_reset();
    start = cyc;
    for (int i = 0; i < 3; i++) begin
      ord_q.push_back(0); ord_q.push_back(1);
    end
    push_op(0, 1'b0, 16'h0001, 32'h0, 1'b0, 32'h080d0002, 0);
    push_op(0, 1'b0, 16'h0002, 32'h0, 1'b0, 32'h080d0003, 0);
    push_op(0, 1'b0, 16'h0003, 32'h0, 1'b0, 32'h080d0004, 0);
    push_op(1, 1'b0, 16'h0004, 32'h0, 1'b0, 32'h080d0005, 0);
    push_op(1, 1'b0, 16'h0005, 32'h0, 1'b0, 32'h080d0006, 0);
    push_op(1, 1'b0, 16'h0006, 32'h0, 1'b0, 32'h080d0007, 0);
    wait_done("t2");
    chk("t2_last_gnt_cycle", 32'(gnt_cyc[1] - start), 32'd7);
`ifdef DMEM_ARB_STATS_EN
    chk("stat0_acc", stat0_acc, 32'd3);
    chk("stat1_acc", stat1_acc, 32'd3);
    chk("stat0_wait", stat0_wait, 32'd3);
    chk("stat1_wait", stat1_wait, 32'd4);
`endif

    // 3: locked burst by m1 capped at 8 while m0 waits
    do_reset();
    for (int i = 0; i < 8; i++) ord_q.push_back(1);
    ord_q.push_back(0);
    for (int i = 0; i < 8; i++) ord_q.push_back(1);
    for (int i = 0; i < 16; i++)
      push_op(1, 1'b1, 16'h0010 + 16'(i), 32'hA5000000 + 32'(i), 1'b1, 32'h0, 0);
    push_op(0, 1'b0, 16'h0000, 32'h0, 1'b0, 32'h080d0001, 2);
    wait_done("t3");
    ord_q.push_back(0); ord_q.push_back(1);
    push_op(0, 1'b0, 16'h0017, 32'h0, 1'b0, 32'hA5000007, 0);
    push_op(1, 1'b0, 16'h001F, 32'h0, 1'b0, 32'hA500000F, 0);
    wait_done("t3_readback");

    // 4: write by m0 then read of same word by m1 on the next cycle
    do_reset();
    we_cycles = 0;
    ord_q.push_back(0); ord_q.push_back(1);
    push_op(0, 1'b1, 16'h0003, 32'hDEADBEEF, 1'b0, 32'h0, 0);
    push_op(1, 1'b0, 16'h0003, 32'h0, 1'b0, 32'hDEADBEEF, 1);
    wait_done("t4");
    chk("t4_we_cycles", 32'(we_cycles), 32'd1);

    // 5: reset in the middle of a locked m1 burst
    do_reset();
    base = n_gnt[1];
    for (int i = 0; i < 10; i++)
      push_op(1, 1'b1, 16'h0020 + 16'(i), 32'(i), 1'b1, 32'h0, 0);
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk); #1;
      if (n_gnt[1] >= base + 3) hit = 1;
    end
    chk("t5_burst_started", {31'd0, hit}, 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("t5_rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("t5_rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("t5_rst_m1_req_held", {31'd0, req[1]}, 32'd1);
    opq[1].delete();
    drop[1] = 1;
    @(negedge clk);
    rst = 1'b0;
    ord_q.push_back(0); ord_q.push_back(1);
    push_op(0, 1'b0, 16'h0022, 32'h0, 1'b0, 32'h00000002, 0);
    push_op(1, 1'b0, 16'h0023, 32'h0, 1'b0, 32'h080d0024, 0);
    wait_done("t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
